// File: rtl/dmem_lsu_pkg.sv
// Shared encodings for the data-memory load/store unit: access sizes, FSM states,
// latched request record and the default RAM base address.
package dmem_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] DMEM_BASE_DEFAULT = 32'h1001_0000;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    RDWAIT,
    WRITE,
    RESP
  } lsuState_t;

  // Request fields captured on acceptance; wdata is reused for the merged RMW word.
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        isUnsigned;
    logic [1:0]  lane;
    logic [31:0] wdata;
  } lsuReq_t;

endpackage

// File: rtl/dmem_lsu_align.sv
// Lane extraction with sign/zero extension for loads, and lane merge for sub-word stores.
// Purely combinational; no state, no handshake.
module dmem_lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        isUnsigned,
  input  logic [31:0] rdWord,
  input  logic [31:0] stData,
  output logic [31:0] ldValue,
  output logic [31:0] mergedWord
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel    = rdWord[{lane, 3'b000} +: 8];
    halfSel    = rdWord[{lane[1], 4'b0000} +: 16];
    ldValue    = rdWord;
    mergedWord = stData;
    case (size)
      SZ_BYTE: begin
        ldValue    = {{24{~isUnsigned & byteSel[7]}}, byteSel};
        mergedWord = rdWord;
        mergedWord[{lane, 3'b000} +: 8] = stData[7:0];
      end
      SZ_HALF: begin
        ldValue    = {{16{~isUnsigned & halfSel[15]}}, halfSel};
        mergedWord = rdWord;
        mergedWord[{lane[1], 4'b0000} +: 16] = stData[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between core and word-wide RAM: alignment check, load extension, RMW for sub-word stores.
// Accept-to-rsp_valid: error 1, word store 2, load 3, sub-word store 4 edges.
// One request in flight; req_ready only in IDLE, no response backpressure. DMEM_RANGE_CHECK_EN adds a base-relative range check.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int ADDR_W = 9
`ifdef DMEM_RANGE_CHECK_EN
  , parameter logic [31:0] DMEM_BASE = DMEM_BASE_DEFAULT
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsuState_t         state;
  lsuReq_t           cur;
  logic [ADDR_W-1:0] wordIdx;
  logic [31:0]       offset;
  logic              outOfRange;
  logic              reqErr;
  logic [31:0]       ldValue;
  logic [31:0]       mergedWord;
  logic              unusedAddrBits;

`ifdef DMEM_RANGE_CHECK_EN
  assign offset     = req_addr - DMEM_BASE;
  assign outOfRange = (offset >= (32'd4 << ADDR_W));
`else
  assign offset     = req_addr;
  assign outOfRange = 1'b0;
`endif

  // Without the range check the upper address bits are dropped so accesses wrap.
  assign unusedAddrBits = &{1'b0, offset[31:ADDR_W+2]};

  always_comb begin
    reqErr = outOfRange;
    case (req_size)
      SZ_BYTE: ;
      SZ_HALF: if (offset[0]) reqErr = 1'b1;
      SZ_WORD: if (offset[1:0] != 2'b00) reqErr = 1'b1;
      default: reqErr = 1'b1;
    endcase
  end

  dmem_lsu_align u_align (
    .size       (cur.size),
    .lane       (cur.lane),
    .isUnsigned (cur.isUnsigned),
    .rdWord     (mem_rdata),
    .stData     (cur.wdata),
    .ldValue    (ldValue),
    .mergedWord (mergedWord)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cur       <= '0;
      wordIdx   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cur.we         <= req_we;
            cur.size       <= req_size;
            cur.isUnsigned <= req_unsigned;
            cur.lane       <= offset[1:0];
            cur.wdata      <= req_wdata;
            wordIdx        <= offset[ADDR_W+1:2];
            rsp_err        <= reqErr;
            if (reqErr)
              state <= RESP;
            else if (req_we && req_size == SZ_WORD)
              state <= WRITE;
            else
              state <= READ;
          end
        end
        READ:   state <= RDWAIT;
        RDWAIT: begin
          if (cur.we) begin
            cur.wdata <= mergedWord;
            state     <= WRITE;
          end else begin
            rsp_rdata <= ldValue;
            state     <= RESP;
          end
        end
        WRITE:   state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake and RAM strobes decode straight from the state register so reset clears them at once.
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign mem_we    = (state == WRITE);
  assign mem_addr  = wordIdx;
  assign mem_wdata = cur.wdata;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a synchronous RAM model and an expected-response queue.
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

`ifdef DMEM_RANGE_CHECK_EN
  localparam logic        RANGE_CHK = 1'b1;
  localparam logic [31:0] ABASE     = DMEM_BASE_DEFAULT;
`else
  localparam logic        RANGE_CHK = 1'b0;
  localparam logic [31:0] ABASE     = 32'h0;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] ram [512] = '{default: 32'h0};

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          weCnt;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sbq[$];

  dmem_lsu #(.ADDR_W(9)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic doReq(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] expRdata, input logic expErr, input int expLat,
                       input int expWe, input logic [31:0] expWaddr, input logic [31:0] expWdata,
                       input logic hold);
    exp_t e;
    int lat;
    int weCnt;
    logic [31:0] wAddr;
    logic [31:0] wData;
    e.rdata = expRdata; e.err = expErr; e.lat = expLat;
    e.weCnt = expWe; e.waddr = expWaddr; e.wdata = expWdata;
    sbq.push_back(e);
    @(negedge clk);
    chk({tag, "/ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = hold;
    req_addr = $urandom; req_wdata = $urandom; req_we = 1'($urandom);
    req_size = 2'($urandom); req_unsigned = 1'($urandom);
    lat = 1; weCnt = 0; wAddr = '0; wData = '0;
    while (!rsp_valid && lat < 20) begin
      if (hold) chk({tag, "/busy"}, 32'(req_ready), 32'd0);
      if (mem_we) begin
        weCnt++;
        wAddr = 32'(mem_addr);
        wData = mem_wdata;
      end
      @(posedge clk); #1;
      lat++;
    end
    e = sbq.pop_front();
    chk({tag, "/lat"}, 32'(lat), 32'(e.lat));
    chk({tag, "/err"}, 32'(rsp_err), 32'(e.err));
    chk({tag, "/rdata"}, rsp_rdata, e.rdata);
    chk({tag, "/wecnt"}, 32'(weCnt), 32'(e.weCnt));
    if (e.weCnt != 0) begin
      chk({tag, "/waddr"}, wAddr, e.waddr);
      chk({tag, "/wdata"}, wData, e.wdata);
    end
    @(posedge clk); #1;
    chk({tag, "/pulse"}, 32'(rsp_valid), 32'd0);
    if (hold) begin
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk({tag, "/noaccept"}, 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_WORD;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    #1 rst = 1'b0;
    #1;
    chk("reset/ready", 32'(req_ready), 32'd1);
    chk("reset/rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset/rdata", rsp_rdata, 32'd0);
    chk("reset/err", 32'(rsp_err), 32'd0);
    chk("reset/mem_we", 32'(mem_we), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // word store then load
    doReq("sw", 1, SZ_WORD, 0, ABASE + 32'h08, 32'hDEADBEEF, 32'h0, 0, 2, 1, 32'd2, 32'hDEADBEEF, 0);
    chk("sw/ram", ram[2], 32'hDEADBEEF);
    doReq("lw", 0, SZ_WORD, 0, ABASE + 32'h08, 32'h0, 32'hDEADBEEF, 0, 3, 0, 0, 0, 0);

    // sub-word loads
    doReq("lb",  0, SZ_BYTE, 0, ABASE + 32'h09, 32'h0, 32'hFFFFFFBE, 0, 3, 0, 0, 0, 0);
    doReq("lbu", 0, SZ_BYTE, 1, ABASE + 32'h09, 32'h0, 32'h000000BE, 0, 3, 0, 0, 0, 0);
    doReq("lh",  0, SZ_HALF, 0, ABASE + 32'h0A, 32'h0, 32'hFFFFDEAD, 0, 3, 0, 0, 0, 0);
    doReq("lhu", 0, SZ_HALF, 1, ABASE + 32'h0A, 32'h0, 32'h0000DEAD, 0, 3, 0, 0, 0, 0);
    doReq("lb0", 0, SZ_BYTE, 0, ABASE + 32'h08, 32'h0, 32'hFFFFFFEF, 0, 3, 0, 0, 0, 0);

    // sub-word stores: upper wdata bits must not leak into the merge
    doReq("sb", 1, SZ_BYTE, 0, ABASE + 32'h0B, 32'hFFFFFF12, 32'hFFFFFFEF, 0, 4, 1, 32'd2, 32'h12ADBEEF, 0);
    chk("sb/ram", ram[2], 32'h12ADBEEF);
    doReq("sh", 1, SZ_HALF, 0, ABASE + 32'h08, 32'hABCD3456, 32'hFFFFFFEF, 0, 4, 1, 32'd2, 32'h12AD3456, 0);
    chk("sh/ram", ram[2], 32'h12AD3456);
    doReq("lw2", 0, SZ_WORD, 0, ABASE + 32'h08, 32'h0, 32'h12AD3456, 0, 3, 0, 0, 0, 0);
    doReq("wrap", 0, SZ_WORD, 0, ABASE + 32'h808, 32'h0, 32'h12AD3456, RANGE_CHK,
          RANGE_CHK ? 1 : 3, 0, 0, 0, 0);

    // errors
    doReq("err_lw",  0, SZ_WORD, 0, ABASE + 32'h0A, 32'h0, 32'h12AD3456, 1, 1, 0, 0, 0, 0);
    doReq("err_sh",  1, SZ_HALF, 0, ABASE + 32'h03, 32'hFFFF, 32'h12AD3456, 1, 1, 0, 0, 0, 0);
    doReq("err_sz",  1, 2'b11,   0, ABASE + 32'h08, 32'h55, 32'h12AD3456, 1, 1, 0, 0, 0, 0);
    chk("err/ram", ram[2], 32'h12AD3456);
    chk("err/ram0", ram[0], 32'h0);

    // reset during RDWAIT of a byte store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_unsigned = 1'b0;
    req_addr = ABASE + 32'h08; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst/busy", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst/mem_we", 32'(mem_we), 32'd0);
    chk("rst/idle", 32'(req_ready), 32'd1);
    chk("rst/rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst/quiet", {30'd0, rsp_valid, mem_we}, 32'd0);
    end
    chk("rst/ram", ram[2], 32'h12AD3456);
    chk("rst/ready", 32'(req_ready), 32'd1);

    // req_valid held through a busy load: no second accept
    doReq("hold", 0, SZ_WORD, 0, ABASE + 32'h08, 32'h0, 32'h12AD3456, 0, 3, 0, 0, 0, 1);

    // one past the end of RAM relative to the base
    doReq("range", 0, SZ_WORD, 0, DMEM_BASE_DEFAULT + 32'h800, 32'h0,
          RANGE_CHK ? 32'h12AD3456 : 32'h0, RANGE_CHK, RANGE_CHK ? 1 : 3, 0, 0, 0, 0);
    chk("range/ram", ram[2], 32'h12AD3456);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit placed between the multicycle processor core and the synchronous word-wide data RAM.
- Accepts one memory request at a time from the core: byte, halfword or word, load or store, signed or unsigned.
- Performs alignment checking, sign/zero extension on loads, and read-modify-write for sub-word stores, since the RAM has no byte enables.
- Returns a single-cycle response pulse when the access completes.

Parameters:
- ADDR_W, 9: RAM word-address width; RAM holds 2^ADDR_W 32-bit words.
- DMEM_BASE, 32'h10010000: byte address of RAM word 0; used only when DMEM_RANGE_CHECK_EN is defined.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; right-aligned for sub-word stores.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; holds its value until the next load.
- rsp_err  out  1  qualified by rsp_valid; misaligned, illegal size, or (optional) out of range.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM word index = addr[ADDR_W+1:2].
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data; valid the cycle after mem_addr is sampled.

Behaviour:
- Reset (asynchronous, rst=0):
  - state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_we=0 immediately; mem_we is decoded from state, never registered independently.
- Handshake:
  - Request is accepted on a rising edge with req_valid && req_ready.
  - Address, size, we, unsigned flag and wdata are latched on acceptance; the core's inputs may change afterwards.
  - req_valid asserted while req_ready=0 is ignored, with no queueing.
- No response backpressure; the core always waits for rsp_valid.
- FSM states: IDLE, READ, RDWAIT, WRITE, RESP.
- Transitions from IDLE on accept:
  - error (see below) -> RESP.
  - word store -> WRITE.
  - otherwise -> READ.
- READ: drive mem_addr, mem_we=0 -> RDWAIT.
- RDWAIT: mem_rdata valid.
  - Load: extract lane, extend, register into rsp_rdata -> RESP.
  - Sub-word store: register merged word -> WRITE.
- WRITE: mem_we=1, mem_addr, mem_wdata = merged or full word -> RESP.
- RESP: rsp_valid=1 -> IDLE.
- Latency, counted in edges from the accepting edge to the rsp_valid cycle:
  - error: 1.
  - word store: 2.
  - load: 3.
  - sub-word store: 4.
- Lane selection:
  - byte lane = addr[1:0]; half lane = addr[1].
  - Little-endian: byte 0 = bits 7:0.
- Merge: replace only the addressed lane with the low 8/16 bits of wdata; other bytes keep their read values.
- Error conditions:
  - half with addr[0]=1.
  - word with addr[1:0]≠0.
  - size=11.
  - On error: no RAM access, mem_we stays 0, rsp_rdata unchanged.
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo the RAM size (unless the optional feature is enabled).
- Reset asserted mid-operation: abort; no response pulse; a partial RMW never writes.
- mem_addr holds the latched word index in all non-IDLE states. In IDLE it is a don't-care, but must not glitch mem_we.

Optional Feature:
- Macro: DMEM_RANGE_CHECK_EN.
- With the macro defined:
  - Any request where (req_addr - DMEM_BASE) >= 4*2^ADDR_W is an error, handled like misalignment: IDLE -> RESP, no RAM access.
  - mem_addr is derived from (addr - DMEM_BASE).
- Without the macro: no base subtraction; upper bits ignored (wrap).

Decomposition:
- Package dmem_lsu_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - FSM state enum.
  - DMEM_BASE default constant.
- Sub-module dmem_lsu_align (combinational):
  - inputs: size, lane bits, unsigned flag, read word, store data.
  - outputs: extended load value and merged store word.
  - Instantiated once.
- The FSM and registers stay in dmem_lsu.

Test Plan:
1. Word store then load:
   - Stimulus: SW 0xDEADBEEF @0x08, then LW @0x08.
   - Response: WRITE pulse with mem_addr=2, mem_wdata=0xDEADBEEF, rsp_valid 2 edges after accept; then rsp_rdata=0xDEADBEEF, err=0, rsp_valid 3 edges after accept.
2. Sub-word loads (word 2 = 0xDEADBEEF):
   - LB @0x09 -> 0xFFFFFFBE.
   - LBU @0x09 -> 0x000000BE.
   - LH @0x0A -> 0xFFFFDEAD.
   - LHU @0x0A -> 0x0000DEAD.
3. Sub-word store RMW:
   - Stimulus: SB 0x12 @0x0B, then SH 0x3456 @0x08.
   - Response: RAM word 2 = 0x12ADBEEF after the SB, then 0x12AD3456; rsp_valid 4 edges after each accept; mem_we high exactly one cycle per store.
4. Errors:
   - LW @0x0A, SH @0x03, size=11.
   - Response for each: rsp_valid 1 edge after accept, rsp_err=1, mem_we never asserted, RAM and rsp_rdata unchanged.
5. Reset mid-RMW:
   - Stimulus: SB accepted, rst=0 asserted during RDWAIT.
   - Response: mem_we=0 immediately, state IDLE, no rsp_valid, RAM word unchanged; req_ready=1 after release.
6. Handshake (DMEM_RANGE_CHECK_EN build):
   - Stimulus: req_valid held high during a busy period.
   - Response: no second accept until IDLE.
   - Stimulus: LW @DMEM_BASE+0x800 (ADDR_W=9).
   - Response: rsp_err=1, no RAM access.
